// File: rtl/nes_loader_pkg.sv
// Shared constants and state encodings for the UART program loader.
package nes_loader_pkg;

   localparam logic [7:0] SYNC    = 8'hA5;
   localparam logic [7:0] CMD_PRG = 8'h00;
   localparam logic [7:0] CMD_CHR = 8'h01;

   typedef enum logic [2:0] {
      P_IDLE,
      P_CMD,
      P_AL,
      P_AH,
      P_LL,
      P_LH,
      P_DATA
   } p_state_t;

   typedef enum logic [1:0] {
      R_IDLE,
      R_START,
      R_BITS,
      R_STOP
   } r_state_t;

endpackage

// File: rtl/nes_uart_loader_if.sv
// Memory write port driven by the loader into PRG-ROM / CHR-ROM.
interface nes_uart_loader_if;
   logic [15:0] mem_addr;
   logic [7:0]  mem_data;
   logic        mem_we;
   logic        mem_sel;

   modport master (output mem_addr, output mem_data, output mem_we, output mem_sel);
   modport slave  (input  mem_addr, input  mem_data, input  mem_we, input  mem_sel);
endinterface

// File: rtl/nes_uart_rx.sv
// UART 8N1 receiver: rx synchronizer, mid-bit sampling, byte/framing strobes.
//
// state   | meaning
// R_IDLE  | line idle, waiting for a falling edge
// R_START | half-bit wait, then confirm start bit (high = glitch)
// R_BITS  | sampling 8 data bits LSB first, one per CLOCK_DIV
// R_STOP  | sampling stop bit: 1 -> byte_valid, 0 -> frame_err
module nes_uart_rx
   import nes_loader_pkg::*;
#(
   parameter int CLOCK_DIV = 217
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       rx,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       frame_err
);

   localparam int CW = $clog2(CLOCK_DIV);
   localparam logic [CW-1:0] HALF = CW'(CLOCK_DIV / 2 - 1);
   localparam logic [CW-1:0] FULL = CW'(CLOCK_DIV - 1);

   logic          rx_meta, rx_sync, rx_prev;
   r_state_t      state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [2:0]    bit_idx, bit_nxt;
   logic [7:0]    shift, shift_nxt;

   // Two-flop synchronizer plus one delayed copy for edge detection; idle-high preset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   // Receiver state, bit timer and shift register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state   <= R_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shift   <= '0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         bit_idx <= bit_nxt;
         shift   <= shift_nxt;
      end
   end

   // Next-state and strobes; the bit timer is a down-counter with terminal count at 0.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      bit_nxt    = bit_idx;
      shift_nxt  = shift;
      byte_valid = 1'b0;
      frame_err  = 1'b0;
      case (state)
         R_IDLE: begin
            if (rx_prev && !rx_sync) begin
               state_nxt = R_START;
               cnt_nxt   = HALF;
            end
         end
         R_START: begin
            if (cnt == '0) begin
               if (rx_sync) begin
                  state_nxt = R_IDLE;
               end else begin
                  state_nxt = R_BITS;
                  cnt_nxt   = FULL;
                  bit_nxt   = 3'd0;
               end
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         R_BITS: begin
            if (cnt == '0) begin
               shift_nxt = {rx_sync, shift[7:1]};
               cnt_nxt   = FULL;
               bit_nxt   = bit_idx + 3'd1;
               if (bit_idx == 3'd7) state_nxt = R_STOP;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         R_STOP: begin
            if (cnt == '0) begin
               state_nxt = R_IDLE;
               if (rx_sync) byte_valid = 1'b1;
               else         frame_err  = 1'b1;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         default: state_nxt = R_IDLE;
      endcase
   end

   assign byte_data = shift;

endmodule

// File: rtl/nes_uart_loader.sv
// Serial program loader: framed UART packets -> PRG/CHR write port, CPU held in
// reset while loading. Optional checksum reply on tx: NES_UART_LOADER_ACK_EN.
//
// state  | meaning
// P_IDLE | waiting for sync byte 0xA5
// P_CMD  | command byte: 0x00 PRG, 0x01 CHR, else abandon
// P_AL   | start address low byte
// P_AH   | start address high byte
// P_LL   | length low byte
// P_LH   | length high byte (zero length ends the packet)
// P_DATA | payload bytes, one write each
module nes_uart_loader
   import nes_loader_pkg::*;
#(
   parameter int CLOCK_DIV = 217,
   parameter int TIMEOUT   = 2500000
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              rx,
   output logic              tx,
   nes_uart_loader_if.master mem,
   output logic              cpu_hold,
   output logic              frame_err
);

   localparam int TW = $clog2(TIMEOUT + 1);

   logic          bv, rx_ferr;
   logic [7:0]    rx_byte;
   p_state_t      state, state_nxt;
   logic [15:0]   addr_q, len_q;
   logic [7:0]    data_q;
   logic          we_q, sel_q, hold_q, ferr_q;
   logic [TW-1:0] tmo_cnt;
   logic          tmo_hit, abort, take_cmd, done;

   nes_uart_rx #(.CLOCK_DIV(CLOCK_DIV)) u_rx (
      .clock      (clock),
      .reset_n    (reset_n),
      .rx         (rx),
      .byte_valid (bv),
      .byte_data  (rx_byte),
      .frame_err  (rx_ferr)
   );

   assign tmo_hit = (state != P_IDLE) && (tmo_cnt == '0);
   assign abort   = rx_ferr | tmo_hit;

   // Inter-byte timeout: reloaded on every byte and while idle, counts down otherwise.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)                 tmo_cnt <= TW'(TIMEOUT - 1);
      else if (bv || state == P_IDLE) tmo_cnt <= TW'(TIMEOUT - 1);
      else if (tmo_cnt != '0)       tmo_cnt <= tmo_cnt - 1'b1;
   end

   // Protocol state register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= P_IDLE;
      else          state <= state_nxt;
   end

   // Protocol next-state; a framing error or timeout always wins.
   always_comb begin
      state_nxt = state;
      take_cmd  = 1'b0;
      done      = 1'b0;
      if (abort) begin
         state_nxt = P_IDLE;
      end else begin
         case (state)
            P_IDLE: if (bv && rx_byte == SYNC) state_nxt = P_CMD;
            P_CMD: begin
               if (bv) begin
                  if (rx_byte == CMD_PRG || rx_byte == CMD_CHR) begin
                     take_cmd  = 1'b1;
                     state_nxt = P_AL;
                  end else begin
                     state_nxt = P_IDLE;
                  end
               end
            end
            P_AL: if (bv) state_nxt = P_AH;
            P_AH: if (bv) state_nxt = P_LL;
            P_LL: if (bv) state_nxt = P_LH;
            P_LH: begin
               if (bv) begin
                  if ({rx_byte, len_q[7:0]} == 16'h0000) begin
                     done      = 1'b1;
                     state_nxt = P_IDLE;
                  end else begin
                     state_nxt = P_DATA;
                  end
               end
            end
            P_DATA: begin
               if (we_q && len_q == 16'd1) begin
                  done      = 1'b1;
                  state_nxt = P_IDLE;
               end
            end
            default: state_nxt = P_IDLE;
         endcase
      end
   end

   // Write-port datapath: field capture, one-cycle write, post-write address/length step.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         addr_q <= '0;
         len_q  <= '0;
         data_q <= '0;
         we_q   <= 1'b0;
         sel_q  <= 1'b0;
         hold_q <= 1'b0;
         ferr_q <= 1'b0;
      end else begin
         we_q   <= 1'b0;
         ferr_q <= abort;
         if (abort) begin
            hold_q <= 1'b0;
         end else begin
            if (bv) begin
               case (state)
                  P_CMD: begin
                     if (take_cmd) begin
                        sel_q  <= rx_byte[0];
                        hold_q <= 1'b1;
                     end
                  end
                  P_AL:   addr_q[7:0]  <= rx_byte;
                  P_AH:   addr_q[15:8] <= rx_byte;
                  P_LL:   len_q[7:0]   <= rx_byte;
                  P_LH:   len_q[15:8]  <= rx_byte;
                  P_DATA: begin
                     data_q <= rx_byte;
                     we_q   <= 1'b1;
                  end
                  default: ;
               endcase
            end
            if (state == P_DATA && we_q) begin
               addr_q <= addr_q + 16'd1;
               len_q  <= len_q - 16'd1;
            end
            if (done) hold_q <= 1'b0;
         end
      end
   end

   assign mem.mem_addr = addr_q;
   assign mem.mem_data = data_q;
   assign mem.mem_we   = we_q;
   assign mem.mem_sel  = sel_q;
   assign frame_err    = ferr_q;

`ifdef NES_UART_LOADER_ACK_EN
   localparam int CW = $clog2(CLOCK_DIV);
   localparam logic [CW-1:0] FULL = CW'(CLOCK_DIV - 1);

   logic [7:0]    sum_q;
   logic          tx_busy;
   logic [9:0]    tx_frame;
   logic [3:0]    tx_bit;
   logic [CW-1:0] tx_cnt;

   // Payload checksum, cleared when a new command is accepted.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)                           sum_q <= '0;
      else if (take_cmd)                      sum_q <= '0;
      else if (state == P_DATA && bv && !abort) sum_q <= sum_q + rx_byte;
   end

   // 8N1 transmitter for the checksum reply; frame shifts out LSB first.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tx_busy  <= 1'b0;
         tx_frame <= '1;
         tx_bit   <= '0;
         tx_cnt   <= '0;
      end else if (done) begin
         tx_busy  <= 1'b1;
         tx_frame <= {1'b1, sum_q, 1'b0};
         tx_bit   <= '0;
         tx_cnt   <= FULL;
      end else if (tx_busy) begin
         if (tx_cnt == '0) begin
            tx_cnt <= FULL;
            if (tx_bit == 4'd9) begin
               tx_busy <= 1'b0;
            end else begin
               tx_bit   <= tx_bit + 4'd1;
               tx_frame <= {1'b1, tx_frame[9:1]};
            end
         end else begin
            tx_cnt <= tx_cnt - 1'b1;
         end
      end
   end

   assign tx       = tx_busy ? tx_frame[0] : 1'b1;
   assign cpu_hold = hold_q | tx_busy;
`else
   assign tx       = 1'b1;
   assign cpu_hold = hold_q;
`endif

endmodule

// File: tb/tb_nes_uart_loader.sv
// Bench for nes_uart_loader: packet-level reference model, randomized packets,
// directed boundary cases, per-cycle write-port compare process.
module tb_nes_uart_loader;

   localparam int CD  = 16;
   localparam int TMO = 1000;

   typedef struct packed {
      logic        sel;
      logic [15:0] addr;
      logic [7:0]  data;
   } wr_t;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   logic rx      = 1'b1;
   logic tx, cpu_hold, frame_err;

   nes_uart_loader_if mem();

   nes_uart_loader #(.CLOCK_DIV(CD), .TIMEOUT(TMO)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .rx        (rx),
      .tx        (tx),
      .mem       (mem),
      .cpu_hold  (cpu_hold),
      .frame_err (frame_err)
   );

   always #5 clock = ~clock;

   int         n_chk = 0;
   int         n_fail = 0;
   int         ferr_seen = 0;
   int         ferr_exp = 0;
   logic       ferr_prev = 1'b0;
   wr_t        exp_q[$];
   wr_t        log_q[$];
   logic [7:0] ack_q[$];
   logic [7:0] pkt_data[0:7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_ok);
      rx = 1'b0;
      tick(CD);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         tick(CD);
      end
      rx = stop_ok;
      tick(CD);
      rx = 1'b1;
      tick(stop_ok ? 2 : CD);
   endtask

   // Sends a packet built from its fields; expectations come from the fields directly.
   task automatic send_pkt(input logic [7:0] cmd, input logic [15:0] addr, input int len,
                           input int bad_idx, input int nsend);
      logic [7:0] b[$];
      logic       valid;
      logic       ack;
      logic       exph;
      logic [7:0] sum;
      int         n;
      int         lim;
`ifdef NES_UART_LOADER_ACK_EN
      ack = 1'b1;
`else
      ack = 1'b0;
`endif
      sum   = 8'h00;
      valid = (cmd == 8'h00) || (cmd == 8'h01);
      b.push_back(8'hA5);
      b.push_back(cmd);
      if (valid) begin
         b.push_back(addr[7:0]);
         b.push_back(addr[15:8]);
         b.push_back(len[7:0]);
         b.push_back(len[15:8]);
         for (int k = 0; k < len; k++) b.push_back(pkt_data[k]);
      end
      n   = b.size();
      lim = (nsend < 0 || nsend > n) ? n : nsend;
      for (int i = 0; i < lim; i++) begin
         if (i == bad_idx) begin
            send_byte(b[i], 1'b0);
            ferr_exp++;
            check("hold after bad stop", cpu_hold, 1'b0);
            check("frame_err count", ferr_seen, ferr_exp);
            check("no pending writes", exp_q.size(), 0);
            return;
         end
         if (valid && i >= 6) begin
            exp_q.push_back({cmd[0], 16'(addr + 16'(i - 6)), b[i]});
            sum = sum + b[i];
         end
         if (valid && ack && i == n - 1) ack_q.push_back(sum);
         send_byte(b[i], 1'b1);
         exph = valid && (i >= 1) && ((i < n - 1) || ack);
         check("cpu_hold after byte", cpu_hold, exph);
      end
      if (valid && ack && lim == n) begin
         tick(12 * CD);
         check("cpu_hold after ack", cpu_hold, 1'b0);
      end
      check("writes drained", exp_q.size(), 0);
      check("frame_err count", ferr_seen, ferr_exp);
   endtask

   // Compare process: every write cycle against the expected queue, frame_err pulses, tx idle.
   initial begin : compare_proc
      wr_t got_w;
      wr_t want_w;
      forever begin
         @(negedge clock);
         if (reset_n) begin
            if (mem.mem_we) begin
               got_w = {mem.mem_sel, mem.mem_addr, mem.mem_data};
               log_q.push_back(got_w);
               if (exp_q.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL unexpected write: got %0h, expected none", got_w);
               end else begin
                  want_w = exp_q.pop_front();
                  check("write sel/addr/data", 32'(got_w), 32'(want_w));
               end
            end
            if (frame_err) begin
               ferr_seen++;
               check("frame_err one cycle", ferr_prev, 1'b0);
            end
            ferr_prev = frame_err;
`ifndef NES_UART_LOADER_ACK_EN
            check("tx idle", tx, 1'b1);
`endif
         end else begin
            ferr_prev = 1'b0;
         end
      end
   end

`ifdef NES_UART_LOADER_ACK_EN
   // Decodes each reply frame on tx and matches it to the expected checksum.
   initial begin : ack_mon
      logic [7:0] v;
      forever begin
         @(negedge tx);
         repeat (CD / 2) @(posedge clock);
         #1;
         check("ack start bit", tx, 1'b0);
         for (int i = 0; i < 8; i++) begin
            repeat (CD) @(posedge clock);
            #1;
            v[i] = tx;
         end
         repeat (CD) @(posedge clock);
         #1;
         check("ack stop bit", tx, 1'b1);
         if (ack_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected ack: got %0h, expected none", v);
         end else begin
            check("ack byte", v, ack_q.pop_front());
         end
      end
   end
`endif

   initial begin : watchdog
      #1500000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
      $fatal(1);
   end

   initial begin : stim
      logic found;
      int   r, len, n, bad;
      logic [15:0] addr;

      tick(3);
      check("reset tx", tx, 1'b1);
      check("reset mem_addr", mem.mem_addr, 16'h0000);
      check("reset mem_data", mem.mem_data, 8'h00);
      check("reset mem_we", mem.mem_we, 1'b0);
      check("reset mem_sel", mem.mem_sel, 1'b0);
      check("reset cpu_hold", cpu_hold, 1'b0);
      check("reset frame_err", frame_err, 1'b0);
      reset_n = 1'b1;
      tick(5);

      // PRG load of three bytes at 0x8000
      log_q.delete();
      pkt_data[0] = 8'h11; pkt_data[1] = 8'h22; pkt_data[2] = 8'h33;
      send_pkt(8'h00, 16'h8000, 3, -1, -1);
      check("prg log size", log_q.size(), 3);
      if (log_q.size() == 3) begin
         check("prg w0", log_q[0], {1'b0, 16'h8000, 8'h11});
         check("prg w1", log_q[1], {1'b0, 16'h8001, 8'h22});
         check("prg w2", log_q[2], {1'b0, 16'h8002, 8'h33});
      end

      // CHR load wrapping the address from 0xFFFF to 0x0000
      log_q.delete();
      pkt_data[0] = 8'hAA; pkt_data[1] = 8'hBB;
      send_pkt(8'h01, 16'hFFFF, 2, -1, -1);
      check("chr log size", log_q.size(), 2);
      if (log_q.size() == 2) begin
         check("chr w0", log_q[0], {1'b1, 16'hFFFF, 8'hAA});
         check("chr w1", log_q[1], {1'b1, 16'h0000, 8'hBB});
      end

      // Bad command, then a valid single-byte load
      log_q.delete();
      send_pkt(8'h07, 16'h0000, 0, -1, -1);
      check("bad cmd no writes", log_q.size(), 0);
      pkt_data[0] = 8'h5A;
      send_pkt(8'h00, 16'h1000, 1, -1, -1);
      check("recover log size", log_q.size(), 1);
      if (log_q.size() == 1) check("recover w0", log_q[0], {1'b0, 16'h1000, 8'h5A});

      // Bad stop bit on the first data byte
      log_q.delete();
      pkt_data[0] = 8'h11;
      send_pkt(8'h00, 16'h8000, 2, 6, -1);
      check("ferr no writes", log_q.size(), 0);

      // Stall after the first data byte -> timeout
      log_q.delete();
      send_pkt(8'h00, 16'h8000, 2, -1, 7);
      tick(900);
      check("hold before timeout", cpu_hold, 1'b1);
      check("no ferr before timeout", ferr_seen, ferr_exp);
      tick(200);
      ferr_exp++;
      check("hold after timeout", cpu_hold, 1'b0);
      check("ferr after timeout", ferr_seen, ferr_exp);
      check("timeout one write", log_q.size(), 1);
      if (log_q.size() == 1) check("timeout w0", log_q[0], {1'b0, 16'h8000, 8'h11});

      // Short low glitch while idle
      log_q.delete();
      rx = 1'b0;
      tick(4);
      rx = 1'b1;
      tick(4 * CD);
      check("glitch no ferr", ferr_seen, ferr_exp);
      check("glitch no writes", log_q.size(), 0);
      check("glitch hold", cpu_hold, 1'b0);

`ifdef NES_UART_LOADER_ACK_EN
      // Checksum reply 0x10+0x20+0xF0 = 0x20; hold spans the reply frame
      pkt_data[0] = 8'h10; pkt_data[1] = 8'h20; pkt_data[2] = 8'hF0;
      send_pkt(8'h00, 16'h9000, 3, -1, 8);
      exp_q.push_back({1'b0, 16'h9002, 8'hF0});
      ack_q.push_back(8'h20);
      send_byte(8'hF0, 1'b1);
      tick(130);
      check("hold during ack", cpu_hold, 1'b1);
      tick(50);
      check("hold after ack stop", cpu_hold, 1'b0);
      check("ack consumed", ack_q.size(), 0);
`endif

      // Randomized packets, junk bytes and framing errors
      for (int it = 0; it < 16; it++) begin
         r = $urandom_range(0, 9);
         if (r < 2) begin
            bad = $urandom_range(0, 255);
            if (bad == 8'hA5) bad = 8'h5A;
            send_byte(8'(bad), 1'b1);
            check("junk hold", cpu_hold, 1'b0);
         end else if (r == 2) begin
            send_pkt(8'($urandom_range(2, 255)), 16'h0000, 0, -1, -1);
         end else begin
            len  = $urandom_range(0, 3);
            addr = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
            for (int k = 0; k < 8; k++) pkt_data[k] = 8'($urandom);
            n   = 6 + len;
            bad = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
            send_pkt(8'($urandom_range(0, 1)), addr, len, bad, -1);
         end
      end

      // Reset asserted on the cycle of a data write
      pkt_data[0] = 8'h77; pkt_data[1] = 8'h88;
      send_pkt(8'h00, 16'h4000, 3, -1, 7);
      check("hold in data phase", cpu_hold, 1'b1);
      exp_q.push_back({1'b0, 16'h4001, 8'h88});
      found = 1'b0;
      fork
         send_byte(8'h88, 1'b1);
      join_none
      for (int k = 0; k < 400; k++) begin
         @(negedge clock);
         if (mem.mem_we) begin
            found = 1'b1;
            break;
         end
      end
      check("write seen before reset", found, 1'b1);
      #1 reset_n = 1'b0;
      #1;
      check("reset cpu_hold", cpu_hold, 1'b0);
      check("reset mem_we", mem.mem_we, 1'b0);
      check("reset mem_addr", mem.mem_addr, 16'h0000);
      check("reset frame_err", frame_err, 1'b0);
      wait fork;
      exp_q.delete();
      tick(3);
      reset_n = 1'b1;
      tick(5);

      // Clean packet after the reset
      log_q.delete();
      pkt_data[0] = 8'hC3;
      send_pkt(8'h01, 16'h2000, 1, -1, -1);
      check("post reset log", log_q.size(), 1);
      if (log_q.size() == 1) check("post reset w0", log_q[0], {1'b1, 16'h2000, 8'hC3});

      tick(12 * CD);
      check("final frame_err count", ferr_seen, ferr_exp);
      check("final ack queue", ack_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
